// File: rtl/text_mode_renderer.sv
// Character-cell text renderer: text RAM fetch, font ROM drive, blinking cursor.
// Ports: clk/reset, h_pos/v_pos/active/syncs in, text RAM + font ROM, pixel/syncs out.
module text_mode_renderer #(
    parameter int COLS            = 80,
    parameter int ROWS            = 60,
    parameter int ADDR_W          = 13,
    parameter int BLINK_FRAMES    = 30,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               h_pos,
    input  logic [9:0]               v_pos,
    input  logic                     active_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    output logic [ADDR_W-1:0]        text_addr,
    input  logic [7:0]               text_data,
    output logic [7:0]               font_char,
    output logic [5:0]               font_index,
    input  logic                     font_is_fg,
    input  logic [$clog2(COLS)-1:0]  cursor_x,
    input  logic [$clog2(ROWS)-1:0]  cursor_y,
    input  logic                     cursor_en,
    output logic                     pixel,
    output logic                     active_out,
    output logic                     hsync_out,
    output logic                     vsync_out
);

    localparam int PW = ADDR_W + 4;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0] COLS_P = PW'(COLS);

    logic [6:0]    col;
    logic [6:0]    row;
    logic [PW-1:0] lin_addr;
    logic          in_range;
    logic          cursor_hit;

    assign col      = h_pos[9:3];
    assign row      = v_pos[9:3];
    assign lin_addr = PW'(row) * COLS_P + PW'(col);
    assign in_range = (int'(col) < COLS) && (int'(row) < ROWS);
    assign cursor_hit = (int'(col) == int'(cursor_x))
                     && (int'(row) == int'(cursor_y));

    // Stage 1
    logic [5:0] s1_idx;
    logic       s1_inr, s1_hit, s1_act, s1_hs, s1_vs;
    // Stage 2
    logic       s2_inr, s2_hit, s2_act, s2_hs, s2_vs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            text_addr <= '0;
            s1_idx    <= '0;
            s1_inr    <= 1'b0;
            s1_hit    <= 1'b0;
            s1_act    <= 1'b0;
            s1_hs     <= SYNC_IDLE;
            s1_vs     <= SYNC_IDLE;
        end else begin
            text_addr <= in_range ? lin_addr[ADDR_W-1:0] : '0;
            s1_idx    <= {v_pos[2:0], h_pos[2:0]};
            s1_inr    <= in_range;
            s1_hit    <= cursor_hit;
            s1_act    <= active_in;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            font_index <= '0;
            s2_inr     <= 1'b0;
            s2_hit     <= 1'b0;
            s2_act     <= 1'b0;
            s2_hs      <= SYNC_IDLE;
            s2_vs      <= SYNC_IDLE;
        end else begin
            font_index <= s1_idx;
            s2_inr     <= s1_inr;
            s2_hit     <= s1_hit;
            s2_act     <= s1_act;
            s2_hs      <= s1_hs;
            s2_vs      <= s1_vs;
        end
    end

    // RAM data arrives aligned with the stage-2 registers.
    assign font_char = text_data;

    logic blink_on;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel      <= 1'b0;
            active_out <= 1'b0;
            hsync_out  <= SYNC_IDLE;
            vsync_out  <= SYNC_IDLE;
        end else begin
            pixel      <= s2_act & s2_inr
                        & (font_is_fg ^ (s2_hit & blink_on & cursor_en));
            active_out <= s2_act;
            hsync_out  <= s2_hs;
            vsync_out  <= s2_vs;
        end
    end

    // Blink timing: count vsync assertion edges, normalised to active-high.
    logic          vs_act;
    logic          vs_prev;
    logic          vs_rise;
    logic [CW-1:0] frame_cnt;

    assign vs_act  = vsync_in ^ SYNC_IDLE;
    assign vs_rise = vs_act & ~vs_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev   <= 1'b0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            vs_prev <= vs_act;
            if (vs_rise) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/text_mode_renderer.md
Name: text_mode_renderer

Overview:
- Character-cell text renderer for the VGA path; it is the reader side of the 8x8 ISO-8859-1 font ROM.
- From the VGA timing generator's pixel coordinates it:
  - fetches the character code for the current cell from a synchronous text RAM,
  - drives the font ROM's char/index inputs,
  - returns a registered pixel, with syncs and active delayed to match.
- Adds a frame-counted blinking block cursor. Sits between the VGA timing generator and the colour/DAC output stage.

Parameters:
COLS, 80, text columns (cells of 8 px).
ROWS, 60, text rows (cells of 8 lines).
ADDR_W, 13, text RAM address width; must be >= clog2(COLS*ROWS).
BLINK_FRAMES, 30, frames per cursor blink half-period; must be >= 1.
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low, 0 = asserted high.

Ports:
clk  in  1  pixel clock.
reset  in  1  asynchronous, active-low reset.
h_pos  in  10  current pixel column from timing generator.
v_pos  in  10  current pixel line from timing generator.
active_in  in  1  1 = visible area.
hsync_in  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW.
vsync_in  in  1  vertical sync, polarity per SYNC_ACTIVE_LOW.
text_addr  out  ADDR_W  text RAM read address (registered).
text_data  in  8  text RAM read data, valid 1 cycle after text_addr.
font_char  out  8  character code to font ROM.
font_index  out  6  bit index to font ROM.
font_is_fg  in  1  font ROM pixel (combinational from font_char/font_index).
cursor_x  in  $clog2(COLS)  cursor column.
cursor_y  in  $clog2(ROWS)  cursor row.
cursor_en  in  1  1 = cursor displayed.
pixel  out  1  1 = foreground.
active_out  out  1  active_in delayed 3 cycles.
hsync_out  out  1  hsync_in delayed 3 cycles.
vsync_out  out  1  vsync_in delayed 3 cycles.

Behaviour:
- Cell decode: col = h_pos[9:3], row = v_pos[9:3].
- Cell position: cx = h_pos[2:0], cy = v_pos[2:0]. Glyph bit index = {cy, cx}; bit 0 is the top-left pixel and bits [7:0] are the top line, with LSB leftmost.
- Pipeline, for inputs sampled at cycle N:
  - Stage 1 (N): register text_addr = row*COLS + col. Also register {cy,cx}, the in_range flag, the cursor-hit flag, active, hsync and vsync.
  - Stage 2 (N+1): RAM presents text_data during N+2. font_char = text_data (combinational pass-through). font_index = stage-2 copy of {cy,cx}, registered so it is aligned with text_data during N+2.
  - Stage 3: pixel registered at the end of N+2 and valid during N+3. pixel = active & in_range & (font_is_fg XOR (cursor_hit & blink_on & cursor_en)).
- Total latency from h_pos/v_pos to pixel is 3 cycles. active_out, hsync_out and vsync_out go through exactly the same 3 registers, so pulse widths and alignment are preserved.
- in_range = (col < COLS) & (row < ROWS). When in_range = 0: text_addr = 0 and pixel = 0, regardless of RAM data or cursor.
- When active_in = 0, pixel = 0 three cycles later. text_addr keeps being computed normally (no gating required).
- cursor_hit = (col == cursor_x) & (row == cursor_y), evaluated in stage 1.
- Blink:
  - Frame counter counts vsync assertion edges (inactive->active level of vsync_in), range 0..BLINK_FRAMES-1.
  - On the edge where the count reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - blink_on resets to 1 (cursor visible immediately after reset).
  - cursor_en = 0 does not stop the counter.
  - cursor_x/y may change at any time; the change takes effect for pixels sampled from that cycle on, with no glitch beyond the normal pipeline.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - Outputs: text_addr = 0, font_index = 0, pixel = 0, active_out = 0.
  - hsync_out and vsync_out = inactive level (1 if SYNC_ACTIVE_LOW, else 0).
  - Internal state: all pipeline registers cleared, frame counter = 0, previous-vsync register = inactive.
  - Reset mid-frame: outputs go to reset values immediately. After release, rendering resumes correctly within 3 cycles with no state beyond the pipeline.
- Width rules: the row*COLS+col product is computed at ADDR_W+4 bits and truncated to ADDR_W. Truncation never matters because out-of-range cells are forced to 0.

Test Plan:
1. Reset: hold reset low for 5 cycles -> pixel = 0, active_out = 0, hsync_out = vsync_out = 1, text_addr = 0; after release, the first pixel is valid 3 cycles after the first sampled coordinate.
2. Glyph fetch: RAM model with 0x4C ('L') at address 0 and the real font ROM; sweep h = 0..7 at v = 1 with active = 1 -> pixel sequence 1,1,0,0,0,0,0,0 appearing 3 cycles after the sweep. At v = 0 -> all 0.
3. Addressing: h = 639, v = 479 -> text_addr = 4799 one cycle later. h = 8, v = 8 -> text_addr = 81.
4. Out-of-range and blanking: v = 480 with active = 1 and RAM returning 0xFF-pattern data -> pixel = 0 and text_addr = 0. active_in = 0 over a valid cell -> pixel = 0.
5. Cursor blink: cursor (2,3), cursor_en = 1, space (0x20) in that cell -> all 64 cell pixels = 1. After 30 vsync assertions -> 0. After 60 -> 1 again. cursor_en = 0 -> 0.
6. Sync alignment: 96-cycle hsync pulse and 2-line vsync pulse -> hsync_out/vsync_out are identical pulses delayed exactly 3 cycles. Repeat with SYNC_ACTIVE_LOW = 0 and check reset level = 0.
